// File: rtl/wbc_irq_ctl_pkg.sv
// Shared register map and CTRL bit layout for the wbc_irq_ctl interrupt controller.
package wbc_irq_ctl_pkg;

  localparam int DATA_W = 16;
  localparam int ADR_W  = 2;

  typedef enum logic [ADR_W-1:0] {
    REG_MASK = 2'd0,
    REG_PEND = 2'd1,
    REG_MODE = 2'd2,
    REG_CTRL = 2'd3
  } reg_sel_e;

  localparam int CTRL_GIE = 0;
  localparam int CTRL_ANY = 15;

  function automatic logic [DATA_W-1:0] ctrl_word(input logic gie, input logic any);
    logic [DATA_W-1:0] r;
    r           = '0;
    r[CTRL_GIE] = gie;
    r[CTRL_ANY] = any;
    return r;
  endfunction

endpackage

// File: rtl/wbc_irq_ctl_if.sv
// Register-access bus bundle for wbc_irq_ctl; master drives requests, slave answers.
interface wbc_irq_ctl_if;
  import wbc_irq_ctl_pkg::*;

  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADR_W-1:0]  adr;
  logic [DATA_W-1:0] dat_w;
  logic [DATA_W-1:0] dat_r;
  logic              ack;

  modport master (
    output cyc, stb, we, adr, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w,
    output dat_r, ack
  );

endinterface

// File: rtl/wbc_irq_sync.sv
// One interrupt line: two-flop synchroniser plus rising-edge detector with a
// short warm-up so a line already high at reset release does not look like an edge.
module wbc_irq_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic rise
);

  logic       sync_p0;
  logic       sync_p1;
  logic       hist_p2;
  logic [2:0] warm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= 1'b0;
      warm    <= '0;
    end else begin
      // p0 -> p1: metastability settling; p2: edge history
      sync_p0 <= line;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
      warm    <= {warm[1:0], 1'b1};
    end
  end

  // Edges are only trusted once the synchroniser holds post-reset samples.
  assign level = sync_p1;
  assign rise  = sync_p1 & ~hist_p2 & warm[2];

endmodule

// File: rtl/wbc_irq_ctl.sv
// Interrupt qualifier: per-line sync/edge detect, MASK/PEND/MODE/CTRL registers
// behind a single-cycle-ack register bus, and registered ireq to the vector controller.
module wbc_irq_ctl
  import wbc_irq_ctl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADR_W-1:0]  wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  input  logic [N-1:0]      irq_i,
  output logic [N-1:0]      ireq,
  input  logic [N-1:0]      iack
);

  logic [N-1:0]      level;
  logic [N-1:0]      rise;
  logic [N-1:0]      mask;
  logic [N-1:0]      pend;
  logic [N-1:0]      mode;
  logic [N-1:0]      pend_nxt;
  logic [N-1:0]      wdat;
  logic [N-1:0]      to_edge;
  logic [N-1:0]      w1c;
  logic              gie;
  logic              any;
  logic              bus_armed;
  logic              access;
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] rdata;
  logic              unused_dat;
  reg_sel_e          sel;

  for (genvar gi = 0; gi < N; gi++) begin : g_line
    wbc_irq_sync u_sync (
      .clk   (wb_clk_i),
      .rst_n (wb_rstn_i),
      .line  (irq_i[gi]),
      .level (level[gi]),
      .rise  (rise[gi])
    );
  end

  function automatic logic [DATA_W-1:0] zext(input logic [N-1:0] v);
    logic [DATA_W-1:0] r;
    r        = '0;
    r[N-1:0] = v;
    return r;
  endfunction

  // A bus cycle that straddles reset is never acked: the port re-arms only after stb drops.
  assign sel        = reg_sel_e'(wb_adr_i);
  assign access     = wb_cyc_i & wb_stb_i & ~wb_ack_o & bus_armed;
  assign wr         = access & wb_we_i;
  assign rd         = access & ~wb_we_i;
  assign wdat       = wb_dat_i[N-1:0];
  assign any        = |ireq;
  assign to_edge    = (wr && sel == REG_MODE) ? (wdat & ~mode) : '0;
  assign w1c        = (wr && sel == REG_PEND) ? wdat : '0;
  assign unused_dat = ^wb_dat_i;

  always_comb begin
    rdata = '0;
    case (sel)
      REG_MASK: rdata = zext(mask);
      REG_PEND: rdata = zext(pend);
      REG_MODE: rdata = zext(mode);
      REG_CTRL: rdata = ctrl_word(gie, any);
      default:  rdata = '0;
    endcase
  end

  // Priority per bit: level->edge switch clears, level mode tracks, set beats clear.
  always_comb begin
    pend_nxt = pend;
    for (int i = 0; i < N; i++) begin
      if (to_edge[i])             pend_nxt[i] = 1'b0;
      else if (!mode[i])          pend_nxt[i] = level[i];
      else if (rise[i])           pend_nxt[i] = 1'b1;
      else if (iack[i] || w1c[i]) pend_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      mask      <= '0;
      pend      <= '0;
      mode      <= '0;
      gie       <= 1'b0;
      ireq      <= '0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      bus_armed <= 1'b0;
    end else begin
      wb_ack_o <= access;
      if (!(wb_cyc_i && wb_stb_i)) bus_armed <= 1'b1;
      pend <= pend_nxt;
      // p1: request qualification one cycle behind PEND
      ireq <= pend & mask & {N{gie}};
      if (wr) begin
        case (sel)
          REG_MASK: mask <= wdat;
          REG_MODE: mode <= wdat;
          REG_CTRL: gie  <= wb_dat_i[CTRL_GIE];
          default:  ;
        endcase
      end
      if (rd) wb_dat_o <= rdata;
    end
  end

endmodule

// File: tb/tb_wbc_irq_ctl.sv
// Bench for wbc_irq_ctl: register vector table plus hand-written interrupt sequences.
module tb_wbc_irq_ctl;
  import wbc_irq_ctl_pkg::*;

  localparam int N = 8;

  typedef struct {
    logic        we;
    logic [1:0]  adr;
    logic [15:0] wdat;
    logic [15:0] exp;
    string       nm;
  } vec_t;

  typedef struct {
    string       nm;
    logic [15:0] exp;
  } sb_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] irq   = '0;
  logic [N-1:0] iack  = '0;
  logic [N-1:0] ireq;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  sb_t  sb_q[$];

  wbc_irq_ctl_if bus_if ();

  always #5 clk = ~clk;

  wbc_irq_ctl #(.N(N)) dut (
    .wb_clk_i  (clk),
    .wb_rstn_i (rst_n),
    .wb_cyc_i  (bus_if.cyc),
    .wb_stb_i  (bus_if.stb),
    .wb_we_i   (bus_if.we),
    .wb_adr_i  (bus_if.adr),
    .wb_dat_i  (bus_if.dat_w),
    .wb_dat_o  (bus_if.dat_r),
    .wb_ack_o  (bus_if.ack),
    .irq_i     (irq),
    .ireq      (ireq),
    .iack      (iack)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic we, input logic [1:0] adr, input logic [15:0] wdat,
                         input logic [15:0] exp, input string nm);
    vec_t v;
    v.we = we; v.adr = adr; v.wdat = wdat; v.exp = exp; v.nm = nm;
    tbl.push_back(v);
  endtask

  // One bus access starting at a negedge; reads queue their expectation on issue.
  task automatic bus(input logic w, input logic [1:0] a, input logic [15:0] d,
                     input logic [15:0] e, input string nm);
    int  lat;
    sb_t s;
    if (!w) begin
      s.nm = nm; s.exp = e;
      sb_q.push_back(s);
    end
    bus_if.cyc = 1'b1; bus_if.stb = 1'b1; bus_if.we = w;
    bus_if.adr = a;    bus_if.dat_w = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus_if.ack && lat < 4);
    check({nm, " ack latency"}, lat, 1);
    if (!w && sb_q.size() > 0) begin
      s = sb_q.pop_front();
      check(s.nm, bus_if.dat_r, s.exp);
    end
    bus_if.cyc = 1'b0; bus_if.stb = 1'b0; bus_if.we = 1'b0;
    @(negedge clk);
    check({nm, " ack one cycle"}, bus_if.ack, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus_if.cyc = 1'b0; bus_if.stb = 1'b0; bus_if.we = 1'b0;
    bus_if.adr = '0;   bus_if.dat_w = '0;

    add_vec(1'b0, REG_MASK, 16'h0000, 16'h0000, "reset MASK");
    add_vec(1'b0, REG_PEND, 16'h0000, 16'h0000, "reset PEND");
    add_vec(1'b0, REG_MODE, 16'h0000, 16'h0000, "reset MODE");
    add_vec(1'b0, REG_CTRL, 16'h0000, 16'h0000, "reset CTRL");
    add_vec(1'b1, REG_MASK, 16'hFFFF, 16'h0000, "wr MASK ffff");
    add_vec(1'b0, REG_MASK, 16'h0000, 16'h00FF, "MASK upper bits");
    add_vec(1'b1, REG_MODE, 16'hFFFF, 16'h0000, "wr MODE ffff");
    add_vec(1'b0, REG_MODE, 16'h0000, 16'h00FF, "MODE upper bits");
    add_vec(1'b1, REG_PEND, 16'hFFFF, 16'h0000, "wr PEND ffff");
    add_vec(1'b0, REG_PEND, 16'h0000, 16'h0000, "PEND w1c only");
    add_vec(1'b1, REG_CTRL, 16'hFFFF, 16'h0000, "wr CTRL ffff");
    add_vec(1'b0, REG_CTRL, 16'h0000, 16'h0001, "CTRL gie only");
    add_vec(1'b1, REG_MASK, 16'h00A5, 16'h0000, "wr MASK a5");
    add_vec(1'b0, REG_MASK, 16'h0000, 16'h00A5, "MASK a5");
    add_vec(1'b1, REG_MODE, 16'h1234, 16'h0000, "wr MODE 1234");
    add_vec(1'b0, REG_MODE, 16'h0000, 16'h0034, "MODE 34");
    add_vec(1'b1, REG_CTRL, 16'h0000, 16'h0000, "wr CTRL 0");
    add_vec(1'b0, REG_CTRL, 16'h0000, 16'h0000, "CTRL cleared");

    repeat (3) @(negedge clk);
    check("reset ack", bus_if.ack, 0);
    check("reset dat_o", bus_if.dat_r, 0);
    check("reset ireq", ireq, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    foreach (tbl[i]) bus(tbl[i].we, tbl[i].adr, tbl[i].wdat, tbl[i].exp, tbl[i].nm);

    // Edge mode on line 0: one-cycle pulse, then iack.
    bus(1'b1, REG_MODE, 16'h0001, 16'h0, "wr MODE 1");
    bus(1'b1, REG_MASK, 16'h0001, 16'h0, "wr MASK 1");
    bus(1'b1, REG_CTRL, 16'h0001, 16'h0, "wr CTRL gie");
    irq[0] = 1'b1;
    @(negedge clk);
    irq[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("edge0 ireq", ireq, 8'h01);
    bus(1'b0, REG_PEND, 16'h0, 16'h0001, "edge0 PEND");
    iack[0] = 1'b1;
    @(negedge clk);
    iack[0] = 1'b0;
    check("iack0 ireq after 1", ireq[0], 1);
    @(negedge clk);
    check("iack0 ireq after 2", ireq[0], 0);
    bus(1'b0, REG_PEND, 16'h0, 16'h0000, "iack0 PEND");

    // Level mode on line 3.
    bus(1'b1, REG_MODE, 16'h0000, 16'h0, "wr MODE 0");
    bus(1'b1, REG_MASK, 16'h0008, 16'h0, "wr MASK 8");
    irq[3] = 1'b1;
    repeat (5) @(negedge clk);
    check("level3 ireq", ireq, 8'h08);
    iack[3] = 1'b1;
    @(negedge clk);
    iack[3] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      check("level3 ireq through iack", ireq[3], 1);
    end
    bus(1'b1, REG_PEND, 16'h0008, 16'h0, "wr PEND 8 level");
    bus(1'b0, REG_PEND, 16'h0, 16'h0008, "level3 PEND ignores w1c");
    irq[3] = 1'b0;
    k = 0;
    while (ireq[3] && k < 4) begin
      @(negedge clk);
      k++;
    end
    check("level3 drop ireq", ireq[3], 0);

    // Line 2 edge coinciding with iack.
    bus(1'b1, REG_MODE, 16'h0004, 16'h0, "wr MODE 4");
    irq[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    iack[2] = 1'b1;
    @(negedge clk);
    iack[2] = 1'b0;
    bus(1'b0, REG_PEND, 16'h0, 16'h0004, "edge2 vs iack");
    iack[2] = 1'b1;
    @(negedge clk);
    iack[2] = 1'b0;
    bus(1'b0, REG_PEND, 16'h0, 16'h0000, "iack2 clears");

    // Line 2 edge coinciding with a write-one-to-clear.
    irq[2] = 1'b0;
    repeat (3) @(negedge clk);
    irq[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus(1'b1, REG_PEND, 16'h0004, 16'h0, "w1c same cycle");
    bus(1'b0, REG_PEND, 16'h0, 16'h0004, "edge2 vs w1c");
    bus(1'b1, REG_PEND, 16'h0004, 16'h0, "w1c alone");
    bus(1'b0, REG_PEND, 16'h0, 16'h0000, "w1c clears");

    // GIE gating and ANY.
    bus(1'b1, REG_CTRL, 16'h0000, 16'h0, "wr CTRL 0");
    bus(1'b1, REG_MODE, 16'h0005, 16'h0, "wr MODE 5");
    bus(1'b1, REG_MASK, 16'h00FF, 16'h0, "wr MASK ff");
    irq = '0;
    repeat (4) @(negedge clk);
    bus(1'b1, REG_PEND, 16'h00FF, 16'h0, "clear PEND");
    irq = 8'h05;
    repeat (5) @(negedge clk);
    check("gie0 ireq", ireq, 0);
    bus(1'b0, REG_PEND, 16'h0, 16'h0005, "gie0 PEND");
    bus(1'b0, REG_CTRL, 16'h0, 16'h0000, "gie0 CTRL");
    bus(1'b1, REG_CTRL, 16'h0001, 16'h0, "wr CTRL gie 1");
    check("gie1 ireq", ireq, 8'h05);
    bus(1'b0, REG_CTRL, 16'h0, 16'h8001, "gie1 CTRL any");
    bus(1'b1, REG_MASK, 16'h0001, 16'h0, "wr MASK 1 again");
    check("mask drop ireq", ireq, 8'h01);
    bus(1'b0, REG_PEND, 16'h0, 16'h0005, "mask drop keeps PEND");

    // Reset in the middle of an access, lines held high through release.
    irq = 8'hFF;
    repeat (4) @(negedge clk);
    bus_if.cyc = 1'b1; bus_if.stb = 1'b1; bus_if.we = 1'b0; bus_if.adr = REG_CTRL;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid-access reset ack", bus_if.ack, 0);
    check("mid-access reset dat_o", bus_if.dat_r, 0);
    check("mid-access reset ireq", ireq, 0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (bus_if.ack) k++;
    end
    check("no ack after release", k, 0);
    bus_if.cyc = 1'b0; bus_if.stb = 1'b0;
    @(negedge clk);
    bus(1'b0, REG_MASK, 16'h0, 16'h0000, "post-reset MASK");
    bus(1'b0, REG_MODE, 16'h0, 16'h0000, "post-reset MODE");
    bus(1'b0, REG_CTRL, 16'h0, 16'h0000, "post-reset CTRL");
    bus(1'b1, REG_MODE, 16'h00FF, 16'h0, "post-reset wr MODE ff");
    repeat (4) @(negedge clk);
    bus(1'b0, REG_PEND, 16'h0, 16'h0000, "post-reset PEND high lines");
    check("post-reset ireq", ireq, 0);
    check("scoreboard drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
